// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array and its result drain.
package mac_pkg;

  // Default widths, shared with the MAC array so both sides agree.
  localparam int unsigned DEF_NUM_LANES    = 16;
  localparam int unsigned DEF_OUTPUT_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH   = 16;

  // Widest result the relu helper handles; callers sign-extend into it.
  localparam int unsigned RELU_MAX_W = 64;

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_e;

  // Clamp a signed value to zero when negative.
  function automatic logic signed [RELU_MAX_W-1:0] relu(
    input logic signed [RELU_MAX_W-1:0] v
  );
    return v[RELU_MAX_W-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/mac_result_drain.sv
// Snapshots all MAC lane results in one cycle and streams them out one lane
// per beat with a write-back address and optional ReLU.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int unsigned NUM_LANES      = DEF_NUM_LANES,
  parameter int unsigned OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned LANE_IDX_WIDTH = $clog2(NUM_LANES + 1)
) (
  input  logic                              clk,
  input  logic                              arst_n_in,
  input  logic                              capture_valid,
  output logic                              capture_ready,
  input  logic [NUM_LANES*OUTPUT_WIDTH-1:0] mac_results,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [LANE_IDX_WIDTH-1:0]         lane_count,
  input  logic                              relu_en,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUTPUT_WIDTH-1:0]           out_data,
  output logic [ADDR_WIDTH-1:0]             out_addr,
  output logic                              out_last,
  output logic                              drain_done
);

  drain_state_e                   state_q, state_d;
  logic [LANE_IDX_WIDTH-1:0]      idx_q, idx_d;
  logic [LANE_IDX_WIDTH-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]          base_q, base_d;
  logic                           relu_q, relu_d;
  logic                           done_q, done_d;
  logic signed [OUTPUT_WIDTH-1:0] bank_q [NUM_LANES];
  logic signed [OUTPUT_WIDTH-1:0] bank_d [NUM_LANES];

  logic [LANE_IDX_WIDTH-1:0]      eff_count;
  logic [LANE_IDX_WIDTH-1:0]      last_idx;
  logic                           is_last;
  logic                           beat_fire;
  logic                           cap_fire;
  logic signed [OUTPUT_WIDTH-1:0] lane_val;

  assign out_valid     = (state_q == DRAIN);
  assign last_idx      = cnt_q - LANE_IDX_WIDTH'(1);
  assign is_last       = out_valid && (idx_q == last_idx);
  assign out_last      = is_last;
  assign beat_fire     = out_valid && out_ready;
  // Ready also on the accepted last beat so snapshots can chain without a bubble.
  assign capture_ready = (state_q == IDLE) || (beat_fire && is_last);
  assign cap_fire      = capture_valid && capture_ready;
  assign out_addr      = base_q + ADDR_WIDTH'(idx_q);
  assign drain_done    = done_q;

  // Zero or out-of-range lane counts mean "all lanes".
  always_comb begin
    eff_count = lane_count;
    if (lane_count == '0 || lane_count > LANE_IDX_WIDTH'(NUM_LANES)) begin
      eff_count = LANE_IDX_WIDTH'(NUM_LANES);
    end
  end

  // Select the current lane from the bank and apply the optional ReLU.
  always_comb begin
    lane_val = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (idx_q == LANE_IDX_WIDTH'(i)) lane_val = bank_q[i];
    end
    out_data = relu_q ? OUTPUT_WIDTH'(relu(RELU_MAX_W'(lane_val))) : lane_val;
  end

  // Next-state: beat advance first, then a capture overrides (back-to-back reload).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    relu_d  = relu_q;
    bank_d  = bank_q;
    done_d  = beat_fire && is_last;
    if (beat_fire) begin
      if (is_last) state_d = IDLE;
      else         idx_d   = idx_q + LANE_IDX_WIDTH'(1);
    end
    if (cap_fire) begin
      state_d = DRAIN;
      idx_d   = '0;
      cnt_d   = eff_count;
      base_d  = base_addr;
      relu_d  = relu_en;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        bank_d[i] = mac_results[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      end
    end
  end

  // State, bank and capture registers.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      relu_q  <= 1'b0;
      done_q  <= 1'b0;
      bank_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      relu_q  <= relu_d;
      done_q  <= done_d;
      bank_q  <= bank_d;
    end
  end

endmodule
